// File: rtl/iobus_pkg.sv
// Shared I/O-bus link definitions: command codes, message field widths,
// transmitter state encoding and the nargs-to-byte-count mapping.
package iobus_pkg;

  localparam int CMD_W   = 8;
  localparam int NARGS_W = 2;
  localparam int A1_W    = 8;
  localparam int A2_W    = 16;
  localparam int A3_W    = 16;
  localparam int MSG_W   = NARGS_W + CMD_W + A1_W + A2_W + A3_W;

  // Bit 0 of every command byte distinguishes requests from responses.
  localparam logic MSG_REQ  = 1'b0;
  localparam logic MSG_RESP = 1'b1;

  localparam logic [CMD_W-1:0] CMD_NOP   = 8'h00;
  localparam logic [CMD_W-1:0] CMD_READ  = 8'h10;
  localparam logic [CMD_W-1:0] CMD_WRITE = 8'h20;
  localparam logic [CMD_W-1:0] CMD_EVENT = 8'h40;
  localparam logic [CMD_W-1:0] CMD_PANEL = 8'h90;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_e;

  function automatic logic [2:0] msg_len(input logic [NARGS_W-1:0] nargs);
    case (nargs)
      2'd0:    msg_len = 3'd1;
      2'd1:    msg_len = 3'd2;
      2'd2:    msg_len = 3'd4;
      default: msg_len = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/msg_txq_if.sv
// Message-queue host port plus UART transmitter handshake; the producer/UART
// side uses master, the transmit queue uses slave.
interface msg_txq_if
  import iobus_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic               push;
  logic [CMD_W-1:0]   cmd;
  logic [NARGS_W-1:0] nargs;
  logic [A1_W-1:0]    a1;
  logic [A2_W-1:0]    a2;
  logic [A3_W-1:0]    a3;
  logic               flush;
  logic               full;
  logic [LVL_W-1:0]   level;
  logic               busy;
  logic               drop;
  logic [7:0]         uart_data;
  logic               uart_send;
  logic               uart_busy;

  modport master (
    output push, cmd, nargs, a1, a2, a3, flush, uart_busy,
    input  full, level, busy, drop, uart_data, uart_send
  );

  modport slave (
    input  push, cmd, nargs, a1, a2, a3, flush, uart_busy,
    output full, level, busy, drop, uart_data, uart_send
  );

endinterface

// File: rtl/msg_fifo.sv
// Synchronous message FIFO; full/empty come from an occupancy counter so the
// pointers can wrap freely on log2(DEPTH) bits.
module msg_fifo
  import iobus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [MSG_W-1:0]             wdata,
  output logic [MSG_W-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [MSG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en, rd_en;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A flush kills both the write and the read of the same cycle.
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/msg_txq.sv
// Queued message transmitter: buffers whole messages in msg_fifo and
// serialises them byte by byte to the UART with a send/busy level handshake.
module msg_txq
  import iobus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  msg_txq_if.slave   bus
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [MSG_W-1:0] fifo_rdata;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full, fifo_empty;
  logic             pop, advance;

  tx_state_e        state_q;
  logic [47:0]      sr_q, sr_d;
  logic [2:0]       idx_q, last_q;
  logic             uart_send_q, drop_q;
  logic [7:0]       uart_data_q;

  msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .push  (bus.push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata ({bus.nargs, bus.cmd, bus.a1, bus.a2, bus.a3}),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A flush in the IDLE cycle wins over loading the head.
  assign pop     = (state_q == TX_IDLE) & ~fifo_empty & ~bus.flush;
  assign advance = (state_q == TX_DRAIN) & ~bus.uart_busy & (idx_q != last_q);

  assign bus.full      = fifo_full;
  assign bus.level     = fifo_level;
  assign bus.busy      = (state_q != TX_IDLE) | (fifo_level != '0);
  assign bus.drop      = drop_q;
  assign bus.uart_send = uart_send_q;
  assign bus.uart_data = uart_data_q;

  // Byte payload, MSB byte first; the current byte always sits in sr_q[47:40].
  always_comb begin
    sr_d = sr_q;
    if (pop)          sr_d = fifo_rdata[47:0];
    else if (advance) sr_d = {sr_q[39:0], 8'h00};
  end

  always_ff @(posedge clk_sys) begin
    sr_q <= sr_d;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      uart_send_q <= 1'b0;
      uart_data_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= bus.push & (fifo_full | bus.flush);
      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            idx_q       <= '0;
            last_q      <= msg_len(fifo_rdata[49:48]) - 3'd1;
            uart_send_q <= 1'b1;
            uart_data_q <= fifo_rdata[47:40];
            state_q     <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (bus.uart_busy) begin
            uart_send_q <= 1'b0;
            uart_data_q <= '0;
            state_q     <= TX_DRAIN;
          end
        end
        TX_DRAIN: begin
          if (!bus.uart_busy) begin
            if (idx_q == last_q) begin
              state_q <= TX_IDLE;
            end else begin
              idx_q       <= idx_q + 3'd1;
              uart_send_q <= 1'b1;
              uart_data_q <= sr_q[39:32];
              state_q     <= TX_SEND;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_txq.sv
// Randomised bench for msg_txq: a message-queue reference model plus a
// responsive UART model check every output on every cycle.
module tb_msg_txq;
  import iobus_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [1:0]  nargs;
    logic [7:0]  a1;
    logic [15:0] a2;
    logic [15:0] a3;
  } msg_t;

  typedef enum int {U_WAIT, U_DELAY, U_BUSY, U_DONE} ust_e;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  msg_txq_if #(.DEPTH(DEPTH)) bus ();

  msg_txq #(.DEPTH(DEPTH)) dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  msg_t       mq[$];
  logic [7:0] infl_b[$];
  int         infl_left = 0;
  logic       exp_drop = 1'b0;
  ust_e       ust = U_WAIT;
  int         dcnt, bcnt;
  logic [7:0] cap;
  int         ud0 = 0, ud1 = 1;
  bit         rnd_uart = 0, stall = 0;
  int         n_cap = 0, drop_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte sequence of a message, straight from the link format.
  function automatic void expand(input msg_t m);
    infl_b.delete();
    infl_b.push_back(m.cmd);
    if (m.nargs >= 2'd1) infl_b.push_back(m.a1);
    if (m.nargs >= 2'd2) begin infl_b.push_back(m.a2[15:8]); infl_b.push_back(m.a2[7:0]); end
    if (m.nargs == 2'd3) begin infl_b.push_back(m.a3[15:8]); infl_b.push_back(m.a3[7:0]); end
    infl_left = infl_b.size();
  endfunction

  task automatic model_edge();
    bit   full_pre, do_pop;
    msg_t m;
    full_pre = (mq.size() == DEPTH);
    do_pop   = (infl_left == 0) && (mq.size() != 0) && !bus.flush;
    exp_drop = bus.push && (full_pre || bus.flush);
    if (ust == U_DONE) begin
      infl_left--;
      ust = U_WAIT;
    end
    if (bus.flush) mq.delete();
    else begin
      if (do_pop) expand(mq.pop_front());
      if (bus.push && !full_pre) begin
        m = '{cmd: bus.cmd, nargs: bus.nargs, a1: bus.a1, a2: bus.a2, a3: bus.a3};
        mq.push_back(m);
      end
    end
  endtask

  task automatic check_outputs();
    chk("level", 64'(bus.level), 64'(mq.size()));
    chk("full", 64'(bus.full), 64'(mq.size() == DEPTH));
    chk("busy", 64'(bus.busy), 64'((infl_left > 0) || (mq.size() > 0)));
    chk("drop", 64'(bus.drop), 64'(exp_drop));
    drop_seen += int'(bus.drop);
  endtask

  task automatic raise_busy(input int d1);
    bus.uart_busy = 1'b1;
    bcnt = d1;
    ust = U_BUSY;
  endtask

  task automatic uart_step();
    int d0, d1;
    case (ust)
      U_WAIT: begin
        chk("send_expected", 64'(bus.uart_send), 64'(infl_b.size() != 0));
        if (bus.uart_send && infl_b.size() != 0) begin
          n_cap++;
          cap = infl_b.pop_front();
          chk("byte", 64'(bus.uart_data), 64'(cap));
          d0 = rnd_uart ? int'($urandom_range(0, 3)) : ud0;
          d1 = rnd_uart ? int'($urandom_range(1, 3)) : ud1;
          if (d0 == 0) raise_busy(d1);
          else begin
            dcnt = d0;
            ust = U_DELAY;
          end
        end else begin
          chk("data_idle", 64'(bus.uart_data), 64'd0);
        end
      end
      U_DELAY: begin
        chk("send_hold", 64'(bus.uart_send), 64'd1);
        chk("data_hold", 64'(bus.uart_data), 64'(cap));
        if (!stall) dcnt--;
        if (dcnt == 0) raise_busy(rnd_uart ? int'($urandom_range(1, 3)) : ud1);
      end
      U_BUSY: begin
        chk("send_drop", 64'(bus.uart_send), 64'd0);
        if (!stall) bcnt--;
        if (bcnt == 0) begin
          bus.uart_busy = 1'b0;
          ust = U_DONE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    uart_step();
  endtask

  task automatic do_push(input logic [7:0] c, input logic [1:0] n,
                         input logic [7:0] x1, input logic [15:0] x2, input logic [15:0] x3);
    bus.push = 1'b1; bus.cmd = c; bus.nargs = n; bus.a1 = x1; bus.a2 = x2; bus.a3 = x3;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && infl_left == 0 && ust == U_WAIT) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("drain_timeout", 64'(mq.size() + infl_left), 64'd0);
  endtask

  task automatic wait_caps(input int target);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      if (n_cap >= target) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("cap_timeout", 64'(n_cap), 64'(target));
  endtask

  initial begin
    int base;
    int lens[4] = '{1, 2, 4, 6};
    bus.push = 0; bus.flush = 0; bus.cmd = 0; bus.nargs = 0;
    bus.a1 = 0; bus.a2 = 0; bus.a3 = 0; bus.uart_busy = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_send", 64'(bus.uart_send), 64'd0);
    chk("rst_data", 64'(bus.uart_data), 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_drop", 64'(bus.drop), 64'd0);
    rst_n = 1'b1;

    // Single six-byte message, UART busy 3 cycles per byte.
    ud0 = 0; ud1 = 3; base = n_cap;
    do_push(8'h93, 2'd3, 8'h05, 16'h1234, 16'hABCD);
    drain();
    chk("single_bytes", 64'(n_cap - base), 64'd6);

    // nargs sweep.
    ud0 = 1; ud1 = 1;
    for (int n = 0; n < 4; n++) begin
      base = n_cap;
      do_push(8'h42, 2'(n), 8'($urandom), 16'($urandom), 16'($urandom));
      drain();
      chk("sweep_bytes", 64'(n_cap - base), 64'(lens[n]));
    end

    // Overflow while the UART is stalled.
    ud0 = 1; ud1 = 2; stall = 1; base = n_cap;
    do_push(CMD_EVENT, 2'd0, 8'h00, 16'h0000, 16'h0000);
    tick();
    drop_seen = 0;
    for (int i = 0; i < 6; i++)
      do_push(8'h60 + 8'(i), 2'd1, 8'(i), 16'h0, 16'h0);
    tick();
    chk("ovf_drops", 64'(drop_seen), 64'd2);
    chk("ovf_level", 64'(bus.level), 64'd4);
    chk("ovf_full", 64'(bus.full), 64'd1);
    stall = 0;
    drain();
    chk("ovf_bytes", 64'(n_cap - base), 64'd9);

    // Flush during the second byte of the first message.
    ud0 = 1; ud1 = 2; base = n_cap;
    for (int i = 0; i < 3; i++)
      do_push(CMD_PANEL | 8'(MSG_RESP), 2'd3, 8'(i), 16'($urandom), 16'($urandom));
    wait_caps(base + 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_level", 64'(bus.level), 64'd0);
    drain();
    chk("flush_bytes", 64'(n_cap - base), 64'd6);

    // Long hold of uart_send, then immediate busy.
    ud0 = 9; ud1 = 1;
    do_push(CMD_WRITE, 2'd1, 8'h7E, 16'h0, 16'h0);
    drain();
    ud0 = 0; ud1 = 2;
    do_push(CMD_READ, 2'd2, 8'h11, 16'h2233, 16'h0);
    drain();

    // Random traffic.
    rnd_uart = 1;
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(0, 9) == 0);
      bus.push  = ($urandom_range(0, 2) == 0);
      bus.flush = ($urandom_range(0, 49) == 0);
      bus.cmd = 8'($urandom); bus.nargs = 2'($urandom);
      bus.a1 = 8'($urandom); bus.a2 = 16'($urandom); bus.a3 = 16'($urandom);
      tick();
    end
    bus.push = 0; bus.flush = 0; stall = 0;
    drain();

    // Reset in the middle of a message.
    rnd_uart = 0; ud0 = 4; ud1 = 1; base = n_cap;
    do_push(8'hA5, 2'd3, 8'h01, 16'h0203, 16'h0405);
    do_push(8'hB7, 2'd0, 8'h00, 16'h0, 16'h0);
    wait_caps(base + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_send", 64'(bus.uart_send), 64'd0);
    chk("arst_level", 64'(bus.level), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    mq.delete(); infl_b.delete(); infl_left = 0; ust = U_WAIT;
    bus.uart_busy = 1'b0; exp_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ud0 = 0; ud1 = 1; base = n_cap;
    do_push(8'h3C, 2'd2, 8'hD1, 16'hE2F3, 16'h0);
    drain();
    chk("post_rst_bytes", 64'(n_cap - base), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
